// File: rtl/pong_frame_engine_pkg.sv
// Shared types and constants for the pong frame engine.
// Arena size, colours and the frame sequencer states.
package pong_frame_engine_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_BALL,
    S_ERASE_PAD,
    S_UPDATE,
    S_DRAW_BALL,
    S_DRAW_PAD
  } state_t;

endpackage

// File: rtl/pong_frame_engine_rect.sv
// Raster walker over a runtime-sized rectangle, dx fastest.
// Counters hold the pixel emitted this cycle and return to 0 when idle.
module rect_scanner
  import pong_frame_engine_pkg::*;
#(
  parameter int W = 32,
  parameter int H = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  step,
  input  logic [$clog2(W):0]    w,
  input  logic [$clog2(H):0]    h,
  output logic [$clog2(W)-1:0]  dx,
  output logic [$clog2(H)-1:0]  dy,
  output logic                  active,
  output logic                  done
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  localparam logic [XW:0] ONE_W = 1;
  localparam logic [YW:0] ONE_H = 1;

  logic last_x;
  logic last_y;

  assign last_x = ({1'b0, dx} == w - ONE_W);
  assign last_y = ({1'b0, dy} == h - ONE_H);
  assign active = step;
  assign done   = step & last_x & last_y;

  always_ff @(posedge clk) begin
    if (!resetn || !step || done) begin
      dx <= '0;
      dy <= '0;
    end else if (last_x) begin
      dx <= '0;
      dy <= dy + YW'(1);
    end else begin
      dx <= dx + XW'(1);
    end
  end

endmodule

// File: rtl/pong_frame_engine.sv
// Per-frame ball/paddle engine: erase, update physics, redraw.
// Emits one registered pixel write per cycle for vga_adapter.
module pong_frame_engine
  import pong_frame_engine_pkg::*;
#(
  parameter int X_MIN     = 51,
  parameter int X_MAX     = 109,
  parameter int Y_MIN     = 11,
  parameter int PAD_Y     = 110,
  parameter int BALL_SZ   = 2,
  parameter int PAD_W     = 13,
  parameter int BALL_STEP = 1,
  parameter int PAD_STEP  = 2,
  parameter int BALL_X0   = 60,
  parameter int BALL_Y0   = 60,
  parameter int PAD_X0    = 74
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic [2:0] ball_colour,
  input  logic [2:0] pad_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       miss,
  output logic [3:0] hits
);

  localparam int XW = 5;
  localparam int YW = 2;

  localparam logic signed [8:0] XMIN_S  = 9'(X_MIN);
  localparam logic signed [8:0] XMAX_S  = 9'(X_MAX);
  localparam logic signed [8:0] YMIN_S  = 9'(Y_MIN);
  localparam logic signed [8:0] PADY_S  = 9'(PAD_Y);
  localparam logic signed [8:0] BSZ_S   = 9'(BALL_SZ);
  localparam logic signed [8:0] BEXT_S  = 9'(BALL_SZ - 1);
  localparam logic signed [8:0] PEXT_S  = 9'(PAD_W - 1);
  localparam logic signed [8:0] BSTEP_S = 9'(BALL_STEP);
  localparam logic signed [8:0] PSTEP_S = 9'(PAD_STEP);
  localparam logic signed [8:0] PXMAX_S = 9'(X_MAX - PAD_W + 1);

  state_t state, state_n, ph;

  logic [7:0] bx, bx_n, px, px_n;
  logic [6:0] by, by_n;
  logic       right, right_n, down, down_n;
  logic       hit, lost;
  logic       draw, ball_ph, active, done;
  logic [2:0] pix_c;

  logic [XW-1:0] dx;
  logic [YW-1:0] dy;

  logic signed [8:0] sbx, sby, spx;

  assign sbx = $signed({1'b0, bx});
  assign sby = $signed({2'b00, by});
  assign spx = $signed({1'b0, px});

  // ph is the phase of the pixel registered at the coming edge
  assign ph = (state == S_IDLE && frame_tick) ? S_ERASE_BALL : state;

  assign ball_ph = (ph == S_ERASE_BALL) || (ph == S_DRAW_BALL);
  assign draw    = ball_ph || (ph == S_ERASE_PAD) || (ph == S_DRAW_PAD);

  rect_scanner #(
    .W(32),
    .H(4)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .step   (draw),
    .w      (ball_ph ? 6'(BALL_SZ) : 6'(PAD_W)),
    .h      (ball_ph ? 3'(BALL_SZ) : 3'd1),
    .dx     (dx),
    .dy     (dy),
    .active (active),
    .done   (done)
  );

  always_comb begin
    state_n = state;
    unique case (ph)
      S_IDLE:       state_n = S_IDLE;
      S_ERASE_BALL: state_n = done ? S_ERASE_PAD : S_ERASE_BALL;
      S_ERASE_PAD:  state_n = done ? S_UPDATE : S_ERASE_PAD;
      S_UPDATE:     state_n = S_DRAW_BALL;
      S_DRAW_BALL:  state_n = done ? S_DRAW_PAD : S_DRAW_BALL;
      S_DRAW_PAD:   state_n = done ? S_IDLE : S_DRAW_PAD;
      default:      state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bx_n    = bx;
    by_n    = by;
    right_n = right;
    down_n  = down;
    hit     = 1'b0;
    lost    = 1'b0;
    if (right) begin
      if (sbx + BEXT_S + BSTEP_S > XMAX_S) begin
        bx_n    = 8'(XMAX_S - BEXT_S);
        right_n = 1'b0;
      end else begin
        bx_n = 8'(sbx + BSTEP_S);
      end
    end else if (sbx - BSTEP_S < XMIN_S) begin
      bx_n    = 8'(XMIN_S);
      right_n = 1'b1;
    end else begin
      bx_n = 8'(sbx - BSTEP_S);
    end
    if (!down) begin
      if (sby - BSTEP_S < YMIN_S) begin
        by_n   = 7'(YMIN_S);
        down_n = 1'b1;
      end else begin
        by_n = 7'(sby - BSTEP_S);
      end
    end else if (sby + BEXT_S + BSTEP_S >= PADY_S) begin
      if (sbx <= spx + PEXT_S && sbx + BEXT_S >= spx) begin
        hit    = 1'b1;
        by_n   = 7'(PADY_S - BSZ_S);
        down_n = 1'b0;
      end else begin
        // respawn overrides whatever the x axis decided
        lost    = 1'b1;
        bx_n    = 8'(BALL_X0);
        by_n    = 7'(BALL_Y0);
        right_n = 1'b1;
        down_n  = 1'b0;
      end
    end else begin
      by_n = 7'(sby + BSTEP_S);
    end
  end

  always_comb begin
    px_n = px;
    unique case (1'b1)
      (move_left && !move_right):
        px_n = (spx - PSTEP_S < XMIN_S) ? 8'(XMIN_S) : 8'(spx - PSTEP_S);
      (move_right && !move_left):
        px_n = (spx + PSTEP_S > PXMAX_S) ? 8'(PXMAX_S) : 8'(spx + PSTEP_S);
      default:
        px_n = px;
    endcase
  end

  always_comb begin
    pix_c = COL_BLACK;
    if (ph == S_DRAW_BALL) pix_c = ball_colour;
    if (ph == S_DRAW_PAD)  pix_c = pad_colour;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      bx     <= 8'(BALL_X0);
      by     <= 7'(BALL_Y0);
      px     <= 8'(PAD_X0);
      right  <= 1'b1;
      down   <= 1'b1;
      hits   <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      miss   <= 1'b0;
    end else begin
      state  <= state_n;
      plot   <= active;
      busy   <= (ph != S_IDLE);
      miss   <= (ph == S_UPDATE) && lost;
      x      <= (ball_ph ? bx : px) + 8'(dx);
      y      <= ball_ph ? by + 7'(dy) : 7'(PAD_Y);
      colour <= pix_c;
      if (ph == S_UPDATE) begin
        bx    <= bx_n;
        by    <= by_n;
        right <= right_n;
        down  <= down_n;
        px    <= px_n;
        if (hit && hits != 4'hf) hits <= hits + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_pong_frame_engine.sv
// Directed bench for pong_frame_engine with default parameters.
// Pixel stream of each frame is logged and compared with hand values.
module tb_pong_frame_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic [2:0] ball_colour = 3'b100;
  logic [2:0] pad_colour = 3'b010;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       miss;
  logic [3:0] hits;

  int checks = 0;
  int errors = 0;
  int np, nb, nm, b0;

  logic [7:0] lx [0:63];
  logic [6:0] ly [0:63];
  logic [2:0] lc [0:63];

  always #5 clk = ~clk;

  pong_frame_engine dut (
    .clk         (clk),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .move_left   (move_left),
    .move_right  (move_right),
    .ball_colour (ball_colour),
    .pad_colour  (pad_colour),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .miss        (miss),
    .hits        (hits)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one accepted tick; log 45 cycles of output
  task automatic frame(input logic ml, input logic mr, input bit dup);
    @(negedge clk);
    move_left  = ml;
    move_right = mr;
    frame_tick = 1'b1;
    np = 0;
    nb = 0;
    nm = 0;
    b0 = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      frame_tick = dup && (c == 5);
      if (c == 0) b0 = int'(busy);
      if (plot) begin
        if (np < 64) begin
          lx[np] = x;
          ly[np] = y;
          lc[np] = colour;
        end
        np++;
      end
      if (busy) nb++;
      if (miss) nm++;
    end
    move_left  = 1'b0;
    move_right = 1'b0;
  endtask

  task automatic ball_at(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, int'(lx[17]), ex);
    chk({tag, "_y"}, int'(ly[17]), ey);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex, ey, ec, k;
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_hits", int'(hits), 0);
    resetn = 1'b1;

    // frame 1: full pixel stream
    frame(1'b0, 1'b0, 1'b0);
    chk("f1_busy_rise", b0, 1);
    chk("f1_plots", np, 34);
    chk("f1_busy", nb, 35);
    chk("f1_miss", nm, 0);
    chk("f1_hits", int'(hits), 0);
    k = 0;
    for (int p = 0; p < 4; p++) begin
      ex = 60 + p % 2;
      ey = 60 + p / 2;
      chk("f1_erase_ball", int'({lx[k], ly[k], lc[k]}), int'({8'(ex), 7'(ey), 3'b000}));
      k++;
    end
    for (int p = 0; p < 13; p++) begin
      chk("f1_erase_pad", int'({lx[k], ly[k], lc[k]}), int'({8'(74 + p), 7'(110), 3'b000}));
      k++;
    end
    for (int p = 0; p < 4; p++) begin
      ex = 61 + p % 2;
      ey = 61 + p / 2;
      ec = 4;
      chk("f1_draw_ball", int'({lx[k], ly[k], lc[k]}), int'({8'(ex), 7'(ey), 3'(ec)}));
      k++;
    end
    for (int p = 0; p < 13; p++) begin
      chk("f1_draw_pad", int'({lx[k], ly[k], lc[k]}), int'({8'(74 + p), 7'(110), 3'b010}));
      k++;
    end

    // ticks 2..47, then right edge reached at tick 48
    repeat (46) frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    chk("t48_erase_x", int'(lx[0]), 107);
    ball_at("t48_ball", 108, 108);
    // tick 49: paddle at 74..86 misses ball at 108..109
    frame(1'b0, 1'b0, 1'b0);
    chk("t49_miss", nm, 1);
    chk("t49_erase_x", int'(lx[0]), 108);
    ball_at("t49_respawn", 60, 60);
    chk("t49_hits", int'(hits), 0);
    frame(1'b0, 1'b0, 1'b0);
    ball_at("t50_ball", 61, 59);

    // paddle right to its clamp, then a corner return
    do_reset();
    frame(1'b0, 1'b1, 1'b0);
    chk("pr1_erase_pad", int'(lx[4]), 74);
    chk("pr1_pad", int'(lx[21]), 76);
    repeat (10) frame(1'b0, 1'b1, 1'b0);
    frame(1'b0, 1'b1, 1'b0);
    chk("pr12_pad", int'(lx[21]), 97);
    frame(1'b0, 1'b1, 1'b0);
    chk("pr13_pad", int'(lx[21]), 97);
    repeat (34) frame(1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    ball_at("h48_ball", 108, 108);
    frame(1'b0, 1'b0, 1'b0);
    chk("h49_miss", nm, 0);
    chk("h49_hits", int'(hits), 1);
    ball_at("h49_ball", 108, 108);
    frame(1'b1, 1'b1, 1'b1);
    ball_at("h50_ball", 107, 107);
    chk("h50_pad_hold", int'(lx[21]), 97);
    chk("h50_plots", np, 34);
    chk("h50_busy", nb, 35);

    // reset in the middle of DRAW_BALL
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (plot && colour == ball_colour) found = 1'b1;
      else @(negedge clk);
    end
    chk("mid_draw_seen", int'(found), 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_plot", int'(plot), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_hits", int'(hits), 0);
    resetn = 1'b1;

    // paddle left to its clamp; positions restored by reset
    frame(1'b1, 1'b0, 1'b0);
    chk("pl1_erase_ball_x", int'(lx[0]), 60);
    chk("pl1_erase_ball_y", int'(ly[0]), 60);
    chk("pl1_erase_pad", int'(lx[4]), 74);
    chk("pl1_pad", int'(lx[21]), 72);
    ball_at("pl1_ball", 61, 61);
    repeat (9) frame(1'b1, 1'b0, 1'b0);
    frame(1'b1, 1'b0, 1'b0);
    chk("pl11_pad", int'(lx[21]), 52);
    frame(1'b1, 1'b0, 1'b0);
    chk("pl12_pad", int'(lx[21]), 51);
    repeat (8) frame(1'b1, 1'b0, 1'b0);
    chk("pl20_pad", int'(lx[21]), 51);
    chk("pl20_hits", int'(hits), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
